// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the data-memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C    = 2'd1,
    OWN_P    = 2'd2
  } rd_own_t;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_starve_ctr
// Brief    : Saturating count of consecutive denied programmer cycles; raises
//            force_p_o once the limit is reached.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic Rst,
  input  logic p_req_i,
  input  logic p_gnt_i,
  output logic force_p_o
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!p_req_i || p_gnt_i) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign force_p_o = (starve_cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares the single data-memory port between the core (C, priority)
//            and the UART loader (P); routes 1-cycle read data to its owner.
//            Define MEM_ARB_STARVE_GUARD_EN to bound P latency to STARVE_LIMIT.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [3:0]        c_be,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [3:0]        p_be,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  output logic [3:0]        mem_en,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              c_stall
);

  if (DATA_W != 32 || STARVE_LIMIT < 1) begin : g_bad_params
    $error("mem_port_arbiter: DATA_W must be 32 and STARVE_LIMIT at least 1");
  end

  rd_own_t rd_own_q;
  rd_own_t rd_own_d;
  logic    w_force_p;
  logic    w_p_wins;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk       (clk),
    .Rst       (Rst),
    .p_req_i   (p_req),
    .p_gnt_i   (p_gnt),
    .force_p_o (w_force_p)
  );
`else
  assign w_force_p = 1'b0;
`endif

  // P wins when C is idle, or when the starve guard forces one P access through.
  assign w_p_wins = p_req & (~c_req | w_force_p);
  assign p_gnt    = ~Rst & w_p_wins;
  assign c_gnt    = ~Rst & c_req & ~w_p_wins;
  assign c_stall  = ~Rst & c_req & ~c_gnt;

  always_comb begin
    mem_en   = '0;
    mem_wea  = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (c_gnt) begin
      mem_wea  = c_we;
      mem_en   = c_we ? c_be : BE_ALL;
      mem_addr = c_addr;
      mem_din  = c_wdata;
    end else if (p_gnt) begin
      mem_wea  = p_we;
      mem_en   = p_we ? p_be : BE_ALL;
      mem_addr = p_addr;
      mem_din  = p_wdata;
    end
  end

  always_comb begin
    rd_own_d = OWN_NONE;
    if (c_gnt && !c_we) begin
      rd_own_d = OWN_C;
    end else if (p_gnt && !p_we) begin
      rd_own_d = OWN_P;
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      rd_own_q <= OWN_NONE;
    end else begin
      rd_own_q <= rd_own_d;
    end
  end

  assign c_rvalid = (rd_own_q == OWN_C);
  assign p_rvalid = (rd_own_q == OWN_P);
  assign c_rdata  = c_rvalid ? mem_dout : '0;
  assign p_rdata  = p_rvalid ? mem_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Randomised scoreboard bench for mem_port_arbiter with a BRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int LIMIT = 8;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          is_p;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  req_t        rc  = '0;
  req_t        rp  = '0;
  logic        c_gnt, c_rvalid, p_gnt, p_rvalid, mem_wea, c_stall;
  logic [31:0] c_rdata, p_rdata, mem_addr, mem_din;
  logic [3:0]  mem_en;
  logic [31:0] mem_dout = '0;
  logic [31:0] bram    [64];
  logic [31:0] ref_mem [64];
  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          p_wait = 0;
  logic        m_cg, m_pg, s_cg, s_pg, s_stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk      (clk),
    .Rst      (rst),
    .c_req    (rc.req),
    .c_we     (rc.we),
    .c_be     (rc.be),
    .c_addr   (rc.addr),
    .c_wdata  (rc.wdata),
    .c_gnt    (c_gnt),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .p_req    (rp.req),
    .p_we     (rp.we),
    .p_be     (rp.be),
    .p_addr   (rp.addr),
    .p_wdata  (rp.wdata),
    .p_gnt    (p_gnt),
    .p_rvalid (p_rvalid),
    .p_rdata  (p_rdata),
    .mem_en   (mem_en),
    .mem_wea  (mem_wea),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .c_stall  (c_stall)
  );

  // BRAM: registered read; garbage on the data bus whenever no read was issued.
  always @(posedge clk) begin
    if (mem_en != 4'd0 && !mem_wea) mem_dout <= bram[mem_addr[7:2]];
    else                            mem_dout <= $urandom;
    if (mem_wea) begin
      for (int b = 0; b < 4; b++)
        if (mem_en[b]) bram[mem_addr[7:2]][8*b +: 8] <= mem_din[8*b +: 8];
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic req_t mk_rd(logic [31:0] a);
    req_t r;
    r.req = 1'b1; r.we = 1'b0; r.be = 4'($urandom_range(15)); r.addr = a; r.wdata = $urandom;
    return r;
  endfunction

  function automatic req_t mk_wr(logic [31:0] a, logic [3:0] be, logic [31:0] d);
    req_t r;
    r.req = 1'b1; r.we = 1'b1; r.be = be; r.addr = a; r.wdata = d;
    return r;
  endfunction

  function automatic req_t rnd_req(int unsigned pct);
    req_t r;
    r.req   = ($urandom_range(99) < pct);
    r.we    = 1'($urandom_range(1));
    r.be    = 4'($urandom_range(15));
    r.addr  = {24'd0, 6'($urandom_range(63)), 2'b00};
    r.wdata = $urandom;
    return r;
  endfunction

  // Reference model: decide the winner from the arbitration rules, predict the
  // memory drive, update the shadow memory and queue expected read responses.
  function automatic void check_cycle();
    logic        p_wins;
    logic [3:0]  e_en;
    logic        e_we;
    logic [31:0] e_addr, e_din;
    req_t        g;
    p_wins = rp.req && (!rc.req || (GUARD && p_wait >= LIMIT));
    m_pg   = !rst && p_wins;
    m_cg   = !rst && rc.req && !p_wins;
    s_cg = c_gnt; s_pg = p_gnt; s_stall = c_stall;
    chk("c_gnt",   32'(c_gnt),   32'(m_cg));
    chk("p_gnt",   32'(p_gnt),   32'(m_pg));
    chk("c_stall", 32'(c_stall), 32'(!rst && rc.req && !m_cg));
    e_en = '0; e_we = 1'b0; e_addr = '0; e_din = '0;
    if (m_cg || m_pg) begin
      g      = m_cg ? rc : rp;
      e_we   = g.we;
      e_en   = g.we ? g.be : 4'hF;
      e_addr = g.addr;
      e_din  = g.wdata;
      if (g.we) begin
        for (int b = 0; b < 4; b++)
          if (g.be[b]) ref_mem[g.addr[7:2]][8*b +: 8] = g.wdata[8*b +: 8];
      end else begin
        sb.push_back('{is_p: m_pg, data: ref_mem[g.addr[7:2]]});
      end
    end
    chk("mem_en",   32'(mem_en),  32'(e_en));
    chk("mem_wea",  32'(mem_wea), 32'(e_we));
    chk("mem_addr", mem_addr,     e_addr);
    chk("mem_din",  mem_din,      e_din);
    if (rst || !rp.req || m_pg) p_wait = 0;
    else                        p_wait++;
  endfunction

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: at most one read is outstanding per cycle boundary.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("c_rvalid", 32'(c_rvalid), 32'(!e.is_p));
        chk("p_rvalid", 32'(p_rvalid), 32'(e.is_p));
        chk("c_rdata",  c_rdata, e.is_p ? 32'd0 : e.data);
        chk("p_rdata",  p_rdata, e.is_p ? e.data : 32'd0);
      end else begin
        chk("c_rvalid_idle", 32'(c_rvalid), 32'd0);
        chk("p_rvalid_idle", 32'(p_rvalid), 32'd0);
        chk("c_rdata_idle",  c_rdata, 32'd0);
        chk("p_rdata_idle",  p_rdata, 32'd0);
      end
    end
  end

  initial begin : stim
    int          found;
    logic        stall_at;
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      bram[i]    = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
      ref_mem[i] = bram[i];
    end
    bram[4]    = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;

    // Requests held during reset must not be granted.
    rc = mk_rd(32'h44);
    rp = mk_rd(32'h48);
    step();
    step();
    rc = '0; rp = '0;
    rst = 1'b0;
    step();

    // Reset arrives in the cycle a C read would return: the read is dropped.
    rc = mk_rd(32'h40);
    step();
    rc  = '0;
    rst = 1'b1;
    sb.delete();
    step();
    chk("midreset_c_rvalid", 32'(c_rvalid), 32'd0);
    rst = 1'b0;
    step();
    step();

    // C alone.
    rc = mk_rd(32'h10);
    step();
    chk("calone_gnt", 32'(s_cg), 32'd1);
    chk("calone_rdata", c_rdata, 32'hDEAD_BEEF);
    rc = '0;
    step();

    // Contention: C wins, P follows once C drops.
    rc = mk_rd(32'h14);
    rp = mk_rd(32'h18);
    step();
    chk("cont_c_gnt", 32'(s_cg), 32'd1);
    chk("cont_p_gnt", 32'(s_pg), 32'd0);
    chk("cont_stall", 32'(s_stall), 32'd0);
    rc = '0;
    step();
    chk("cont_p_late_gnt", 32'(s_pg), 32'd1);
    rp = '0;
    step();

    // P byte write, then read it back through C.
    rp = mk_wr(32'h8, 4'b0010, 32'h0000_AB00);
    step();
    chk("bw_p_gnt", 32'(s_pg), 32'd1);
    rp = '0;
    step();
    rc = mk_rd(32'h8);
    step();
    w = 32'h0202_0202 ^ 32'h5A5A_0000;
    w[15:8] = 8'hAB;
    chk("bw_readback", c_rdata, w);
    rc = '0;
    step();

    // C requests every cycle while P waits.
    rp = mk_rd(32'h20);
    rc = mk_rd(32'h24);
    found = -1;
    stall_at = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (s_pg) begin
        found = k;
        stall_at = s_stall;
        break;
      end
      rc = mk_rd({24'd0, 6'($urandom_range(63)), 2'b00});
    end
    if (GUARD) begin
      chk("starve_p_gnt_cycle", 32'(found), 32'(LIMIT));
      chk("starve_c_stall", 32'(stall_at), 32'd1);
      rp = mk_rd(32'h28);
      rc = mk_rd(32'h2C);
      step();
      chk("starve_cnt_cleared", 32'(s_pg), 32'd0);
    end else begin
      chk("strict_p_never_gnt", 32'(found < 0), 32'd1);
    end
    if (s_cg) rc = '0;
    rc = '0;
    step();
    rp = '0;
    step();

    // Back-to-back interleave C, P, C.
    rc = mk_rd(32'h30);
    step();
    rc = '0;
    rp = mk_rd(32'h34);
    step();
    rp = '0;
    rc = mk_rd(32'h38);
    step();
    rc = '0;
    step();
    step();

    // Random traffic.
    rc = rnd_req(70);
    rp = rnd_req(50);
    for (int n = 0; n < 600; n++) begin
      step();
      if (m_cg || !rc.req) rc = rnd_req(70);
      if (m_pg || !rp.req) rp = rnd_req(50);
    end

    // Drain: let pending requests finish before going idle.
    for (int n = 0; n < 40 && (rc.req || rp.req); n++) begin
      step();
      if (m_cg) rc = '0;
      if (m_pg) rp = '0;
    end
    chk("drain_done", 32'(rc.req || rp.req), 32'd0);
    rc = '0; rp = '0;
    step();
    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
